// File: rtl/jump_target_unit.sv
// Next-PC target generator with a registered valid/ready output stage.
// The optional return-address stack is built only when JUMP_TGT_RAS_EN is defined.
module jump_target_unit #(
    parameter int ADDR_W    = 32,
    parameter int IDX_W     = 26,
    parameter int IMM_W     = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [1:0]                     req_mode,
    input  logic                           req_link,
    input  logic                           req_ret,
    input  logic [ADDR_W-1:0]              req_pc_plus4,
    input  logic [IDX_W-1:0]               req_index,
    input  logic [IMM_W-1:0]               req_imm,
    input  logic [ADDR_W-1:0]              req_reg,
    input  logic                           flush,
    output logic                           tgt_valid,
    input  logic                           tgt_ready,
    output logic [ADDR_W-1:0]              tgt_addr,
    output logic                           tgt_taken,
    output logic                           tgt_ras_hit,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [1:0] MODE_SEQ    = 2'b00;
    localparam logic [1:0] MODE_JUMP   = 2'b01;
    localparam logic [1:0] MODE_BRANCH = 2'b10;
    localparam logic [1:0] MODE_REG    = 2'b11;

    // The low IDX_W+2 bits are replaced; any remaining upper bits come from pc_plus4.
    function automatic logic [ADDR_W-1:0] jump_target(input logic [ADDR_W-1:0] pc,
                                                      input logic [IDX_W-1:0]  idx);
        logic [ADDR_W-1:0] t;
        t = pc;
        t[IDX_W+1:0] = {idx, 2'b00};
        return t;
    endfunction

    function automatic logic [ADDR_W-1:0] branch_target(input logic [ADDR_W-1:0] pc,
                                                        input logic [IMM_W-1:0]  imm);
        logic signed [ADDR_W-1:0] off;
        off = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};
        return pc + $unsigned(off <<< 2);
    endfunction

    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic              taken_p1;
    logic              hit_p1;

    logic              accept_p0;
    logic              pop_p0;
    logic [ADDR_W-1:0] ras_top_p0;
    logic [ADDR_W-1:0] addr_p0;

    assign req_ready = !flush && (!vld_p1 || tgt_ready);
    assign accept_p0 = req_valid && req_ready;

`ifdef JUMP_TGT_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr;
    logic [PTR_W-1:0]  top_idx;
    logic [CNT_W-1:0]  ras_cnt;
    logic              push_p0;

    // ras_ptr is the next free slot; the pointer wraps so a full stack overwrites its oldest entry.
    assign top_idx    = ras_ptr - PTR_W'(1);
    assign ras_top_p0 = ras_mem[top_idx];
    assign pop_p0     = accept_p0 && (req_mode == MODE_REG) && req_ret && (ras_cnt != '0);
    assign push_p0    = accept_p0 && req_link;
    assign ras_count  = ras_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else if (push_p0 && pop_p0) begin
            ras_mem[top_idx] <= req_pc_plus4;
        end else if (push_p0) begin
            ras_mem[ras_ptr] <= req_pc_plus4;
            ras_ptr          <= ras_ptr + PTR_W'(1);
            if (ras_cnt != CNT_W'(RAS_DEPTH)) begin
                ras_cnt <= ras_cnt + CNT_W'(1);
            end
        end else if (pop_p0) begin
            ras_ptr <= top_idx;
            ras_cnt <= ras_cnt - CNT_W'(1);
        end
    end
`else
    logic unused_ras;

    assign unused_ras = req_link ^ req_ret;
    assign pop_p0     = 1'b0;
    assign ras_top_p0 = '0;
    assign ras_count  = '0;
`endif

    // Stage p0: select the target for the request being offered
    always_comb begin
        addr_p0 = req_pc_plus4;
        case (req_mode)
            MODE_SEQ:    addr_p0 = req_pc_plus4;
            MODE_JUMP:   addr_p0 = jump_target(req_pc_plus4, req_index);
            MODE_BRANCH: addr_p0 = branch_target(req_pc_plus4, req_imm);
            MODE_REG:    addr_p0 = pop_p0 ? ras_top_p0 : req_reg;
            default:     addr_p0 = req_pc_plus4;
        endcase
    end

    // Stage p1: output register; flush drops valid but keeps the last address
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            addr_p1  <= '0;
            taken_p1 <= 1'b0;
            hit_p1   <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept_p0) begin
            vld_p1   <= 1'b1;
            addr_p1  <= addr_p0;
            taken_p1 <= (req_mode != MODE_SEQ);
            hit_p1   <= pop_p0;
        end else if (tgt_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign tgt_valid   = vld_p1;
    assign tgt_addr    = addr_p1;
    assign tgt_taken   = taken_p1;
    assign tgt_ras_hit = hit_p1;

endmodule

// File: doc/jump_target_unit.md
# jump_target_unit

Parametrised next-PC target generator for the IF stage, successor to the fixed 32-bit jump-address concatenator. Each accepted request computes one of four targets: sequential, pseudo-direct jump, PC-relative branch or register jump. Targets are registered behind a valid/ready output stage with flush. An optional return-address stack supplies register-jump targets for subroutine returns.

## Interface
- ADDR_W, 32, address width; ADDR_W >= IDX_W+2 required.
- IDX_W, 26, jump index field width.
- IMM_W, 16, branch offset field width; IMM_W+2 <= ADDR_W required.
- RAS_DEPTH, 4, return-address stack entries (power of two, >= 2); ignored without macro.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_mode  in  2  00 seq, 01 jump, 10 branch, 11 register.
- req_link  in  1  push req_pc_plus4 onto RAS (jal/jalr).
- req_ret  in  1  return hint; valid only with req_mode=11.
- req_pc_plus4  in  ADDR_W  address of following instruction.
- req_index  in  IDX_W  jump index.
- req_imm  in  IMM_W  signed word offset.
- req_reg  in  ADDR_W  register operand.
- flush  in  1  discard output stage.
- tgt_valid  out  1  target held.
- tgt_ready  in  1  consumer accepts target.
- tgt_addr  out  ADDR_W  target address.
- tgt_taken  out  1  1 unless mode was seq.
- tgt_ras_hit  out  1  target came from RAS.
- ras_count  out  $clog2(RAS_DEPTH+1)  live RAS entries.

## Operation
- Seq: tgt = req_pc_plus4.
- Jump: tgt = {req_pc_plus4[ADDR_W-1:IDX_W+2], req_index, 2'b00}; when ADDR_W == IDX_W+2, no upper bits.
- Branch: tgt = req_pc_plus4 + (sign_extend(req_imm) << 2), truncated mod 2^ADDR_W; wraps silently.
- Register: tgt = req_reg unchanged (no alignment forcing), unless RAS hit (see Configuration).
- req_ready = !flush && (!tgt_valid || tgt_ready).
- Output register loads on accept; holds stable while tgt_valid && !tgt_ready.
- Accept while current target consumed: replace in the same edge, no bubble.
- flush: tgt_valid = 0 next cycle; no request accepted in the flush cycle; tgt_addr keeps its last value.
- RAS push on accepted req_link: store req_pc_plus4 at top; count saturates at RAS_DEPTH; when full, oldest entry is overwritten (circular).
- RAS pop on accepted req_mode=11 && req_ret && count>0.
- Push and pop in the same accept: pop read first, then push at the same slot; count unchanged.
- req_ret ignored for modes 00–10. Flush does not roll back the RAS.

## Timing
- Latency: request accepted at edge N; target visible after edge N, valid in cycle N+1.
- Throughput: one target per cycle when tgt_ready held high.
- Reset: tgt_valid=0, tgt_addr=0, tgt_taken=0, tgt_ras_hit=0, ras_count=0, RAS contents=0; req_ready=1 in the first cycle after reset deasserts.
- Reset mid-transfer drops the held target; reset dominates flush and accept.
- All outputs except req_ready are registered.

## Configuration
- JUMP_TGT_RAS_EN defined: RAS built; a popped entry becomes tgt_addr with tgt_ras_hit=1; on an empty pop, req_reg is used and tgt_ras_hit=0.
- JUMP_TGT_RAS_EN undefined: no stack storage; req_link and req_ret ignored; register mode always uses req_reg; tgt_ras_hit and ras_count tied to 0.

## Test plan
- Jump, pc_plus4=0x40001004, index=0x0000100 -> tgt_addr=0x40000400, tgt_taken=1, one cycle later.
- Branch, pc_plus4=0x00000010, imm=0xFFFF -> tgt_addr=0x0000000C; pc_plus4=0xFFFFFFFC, imm=0x0001 -> tgt_addr=0x00000000 (wrap).
- Backpressure: tgt_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, tgt_addr stable; tgt_ready=1 -> next request loads same edge.
- Flush with tgt_valid=1 and req_valid=1 -> tgt_valid=0 next cycle, request not accepted, accepted the following cycle.
- With macro, RAS_DEPTH=4: five link pushes 0x10,0x20,0x30,0x40,0x50 -> ras_count=4; five returns with req_reg=0xAA -> 0x50,0x40,0x30,0x20 with ras_hit=1, then 0xAA with ras_hit=0.
- Without macro: link then return with req_reg=0x1234 -> tgt_addr=0x1234, ras_hit=0, ras_count=0.
